// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer: preamble, SFD, payload, pad, FCS, inter-frame gap
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int ADD_FCS      = 1,
    parameter int IFG_LEN      = 12,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 tx_clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [7:0]           txd,
    output logic                 tx_en,
    output logic                 tx_er,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] underrun_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DROP,
        ST_IFG
    } state_t;

    // Each state names the byte being decided at the coming edge; the wire
    // shows it one cycle later because txd/tx_en/tx_er are registered.
    localparam logic [7:0]  PRE_END  = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_END  = 8'(IFG_LEN - 1);
    localparam logic [16:0] MIN_PAY  = 17'(MIN_PAYLOAD);
    localparam logic        HAS_FCS  = (ADD_FCS != 0);
    localparam logic        HAS_PRE  = (PREAMBLE_LEN > 1);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [7:0]     r_txd;
    logic           r_tx_en;
    logic           r_tx_er;
    logic [31:0]    r_crc;
    logic [7:0]     r_cnt;
    logic [15:0]    r_bytes;
    logic [CNT_WIDTH-1:0] r_frame_count;
    logic [CNT_WIDTH-1:0] r_underrun_count;

    logic [7:0]     w_txd_nxt;
    logic           w_tx_en_nxt;
    logic           w_tx_er_nxt;
    logic [31:0]    w_crc_nxt;
    logic [7:0]     w_cnt_nxt;
    logic [15:0]    w_bytes_nxt;
    logic           w_frame_done;
    logic           w_underrun;
    logic [16:0]    w_bytes_inc;
    logic [15:0]    w_bytes_sat;
    logic [31:0]    w_crc_inv;
    logic [7:0]     w_fcs_byte;

    // Reflected CRC32, one byte per call, LSB of the byte processed first
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // The byte counter includes pad bytes and saturates rather than wrapping
    assign w_bytes_inc = {1'b0, r_bytes} + 17'd1;
    assign w_bytes_sat = (r_bytes == 16'hFFFF) ? r_bytes : w_bytes_inc[15:0];
    assign w_crc_inv   = ~r_crc;

    // FCS goes out least significant byte first
    always_comb begin
        w_fcs_byte = 8'h00;
        case (r_cnt[1:0])
            2'd0:    w_fcs_byte = w_crc_inv[7:0];
            2'd1:    w_fcs_byte = w_crc_inv[15:8];
            2'd2:    w_fcs_byte = w_crc_inv[23:16];
            default: w_fcs_byte = w_crc_inv[31:24];
        endcase
    end

    // State register
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the next wire byte, CRC and counter updates
    always_comb begin
        w_state_nxt  = r_state;
        w_txd_nxt    = 8'h00;
        w_tx_en_nxt  = 1'b0;
        w_tx_er_nxt  = 1'b0;
        w_crc_nxt    = r_crc;
        w_cnt_nxt    = r_cnt;
        w_bytes_nxt  = r_bytes;
        w_frame_done = 1'b0;
        w_underrun   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // First preamble byte is launched here; s_data stays untouched
                if (s_valid) begin
                    w_txd_nxt   = 8'h55;
                    w_tx_en_nxt = 1'b1;
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = HAS_PRE ? ST_PRE : ST_SFD;
                end
            end

            ST_PRE: begin
                w_txd_nxt   = 8'h55;
                w_tx_en_nxt = 1'b1;
                if (r_cnt == PRE_END) begin
                    w_state_nxt = ST_SFD;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            ST_SFD: begin
                w_txd_nxt   = 8'hD5;
                w_tx_en_nxt = 1'b1;
                w_crc_nxt   = CRC_INIT;
                w_bytes_nxt = 16'h0000;
                w_state_nxt = ST_DATA;
            end

            ST_DATA: begin
                w_tx_en_nxt = 1'b1;
                if (s_valid) begin
                    w_txd_nxt   = s_data;
                    w_crc_nxt   = crc_byte(r_crc, s_data);
                    w_bytes_nxt = w_bytes_sat;
                    if (s_last) begin
                        w_cnt_nxt = 8'd0;
                        if (w_bytes_inc < MIN_PAY) begin
                            w_state_nxt = ST_PAD;
                        end else if (HAS_FCS) begin
                            w_state_nxt = ST_FCS;
                        end else begin
                            w_state_nxt  = ST_IFG;
                            w_frame_done = 1'b1;
                        end
                    end
                end else begin
                    // Source starved us mid-frame: poison the frame and flush
                    w_tx_er_nxt = 1'b1;
                    w_underrun  = 1'b1;
                    w_state_nxt = ST_DROP;
                end
            end

            ST_PAD: begin
                w_tx_en_nxt = 1'b1;
                w_crc_nxt   = crc_byte(r_crc, 8'h00);
                w_bytes_nxt = w_bytes_sat;
                if (w_bytes_inc >= MIN_PAY) begin
                    w_cnt_nxt = 8'd0;
                    if (HAS_FCS) begin
                        w_state_nxt = ST_FCS;
                    end else begin
                        w_state_nxt  = ST_IFG;
                        w_frame_done = 1'b1;
                    end
                end
            end

            ST_FCS: begin
                w_txd_nxt   = w_fcs_byte;
                w_tx_en_nxt = 1'b1;
                if (r_cnt == 8'd3) begin
                    w_cnt_nxt    = 8'd0;
                    w_state_nxt  = ST_IFG;
                    w_frame_done = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            ST_DROP: begin
                // Swallow the rest of the aborted frame with the line idle
                if (s_valid && s_last) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_IFG;
                end
            end

            ST_IFG: begin
                if (r_cnt == IFG_END) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered GMII outputs, CRC, byte/step counters and statistics
    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_txd            <= 8'h00;
            r_tx_en          <= 1'b0;
            r_tx_er          <= 1'b0;
            r_crc            <= 32'h0000_0000;
            r_cnt            <= 8'h00;
            r_bytes          <= 16'h0000;
            r_frame_count    <= '0;
            r_underrun_count <= '0;
        end else begin
            r_txd   <= w_txd_nxt;
            r_tx_en <= w_tx_en_nxt;
            r_tx_er <= w_tx_er_nxt;
            r_crc   <= w_crc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bytes <= w_bytes_nxt;
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + CNT_WIDTH'(1);
            end
            if (w_underrun) begin
                r_underrun_count <= r_underrun_count + CNT_WIDTH'(1);
            end
        end
    end

    assign s_ready        = (r_state == ST_DATA) || (r_state == ST_DROP);
    assign busy           = (r_state != ST_IDLE);
    assign txd            = r_txd;
    assign tx_en          = r_tx_en;
    assign tx_er          = r_tx_er;
    assign frame_count    = r_frame_count;
    assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - randomized self-checking bench for gmii_tx_framer against a frame-level model
module tb_gmii_tx_framer;

    localparam int NI = 3;

    logic        tx_clk;
    logic        rst            [NI];
    logic [7:0]  s_data         [NI];
    logic        s_valid        [NI];
    logic        s_last         [NI];
    logic        s_ready        [NI];
    logic [7:0]  txd            [NI];
    logic        tx_en          [NI];
    logic        tx_er          [NI];
    logic        busy           [NI];
    logic [15:0] frame_count    [NI];
    logic [15:0] underrun_count [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] plan_data [$];
    int         plan_len  [$];
    int         plan_hole [$];
    int         plan_off  [$];
    logic       en_q      [$];
    logic       er_q      [$];
    logic [7:0] d_q       [$];
    int         ready_cnt [$];
    int         accepted;
    int         first_start;
    int         first_len;
    int         exp_fc [NI];
    int         exp_uc [NI];

    // Instance 0: defaults; 1: no padding; 2: short preamble, no FCS, 1-cycle gap
    gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_PAYLOAD(60), .ADD_FCS(1), .IFG_LEN(12), .CNT_WIDTH(16)) u_dut_a (
        .tx_clk(tx_clk), .rst(rst[0]), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
        .s_ready(s_ready[0]), .txd(txd[0]), .tx_en(tx_en[0]), .tx_er(tx_er[0]), .busy(busy[0]),
        .frame_count(frame_count[0]), .underrun_count(underrun_count[0]));

    gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_PAYLOAD(0), .ADD_FCS(1), .IFG_LEN(12), .CNT_WIDTH(16)) u_dut_b (
        .tx_clk(tx_clk), .rst(rst[1]), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
        .s_ready(s_ready[1]), .txd(txd[1]), .tx_en(tx_en[1]), .tx_er(tx_er[1]), .busy(busy[1]),
        .frame_count(frame_count[1]), .underrun_count(underrun_count[1]));

    gmii_tx_framer #(.PREAMBLE_LEN(3), .MIN_PAYLOAD(60), .ADD_FCS(0), .IFG_LEN(1), .CNT_WIDTH(16)) u_dut_c (
        .tx_clk(tx_clk), .rst(rst[2]), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_last(s_last[2]),
        .s_ready(s_ready[2]), .txd(txd[2]), .tx_en(tx_en[2]), .tx_er(tx_er[2]), .busy(busy[2]),
        .frame_count(frame_count[2]), .underrun_count(underrun_count[2]));

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    function automatic int cfg_pre(input int i); return (i == 2) ? 3 : 7;  endfunction
    function automatic int cfg_min(input int i); return (i == 1) ? 0 : 60; endfunction
    function automatic int cfg_fcs(input int i); return (i == 2) ? 0 : 1;  endfunction
    function automatic int cfg_ifg(input int i); return (i == 2) ? 1 : 12; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_plan();
        plan_data.delete(); plan_len.delete(); plan_hole.delete(); plan_off.delete();
    endtask

    // hole >= 0: s_valid drops for one cycle once 'hole' bytes of the frame are taken
    task automatic add_frame(input int len, input int hole);
        plan_off.push_back(plan_data.size());
        plan_len.push_back(len);
        plan_hole.push_back(hole);
        for (int k = 0; k < len; k++) plan_data.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic int frame_at(input int p);
        for (int f = 0; f < plan_len.size(); f++)
            if (p < plan_off[f] + plan_len[f]) return f;
        return plan_len.size();
    endfunction

    task automatic sample(input int idx);
        en_q.push_back(tx_en[idx]);
        er_q.push_back(tx_er[idx]);
        d_q.push_back(txd[idx]);
    endtask

    // Feed the planned frames with s_valid held high, then watch the line go idle
    task automatic run_frames(input int idx);
        int ptr, cyc, f;
        bit used [$];
        en_q.delete(); er_q.delete(); d_q.delete(); ready_cnt.delete();
        for (int k = 0; k <= plan_len.size(); k++) ready_cnt.push_back(0);
        for (int k = 0; k < plan_len.size(); k++) used.push_back(1'b0);
        ptr = 0; cyc = 0;
        while ((ptr < plan_data.size()) && (cyc < 20000)) begin
            @(posedge tx_clk); #1;
            f = frame_at(ptr);
            if ((plan_hole[f] >= 0) && (ptr == plan_off[f] + plan_hole[f]) && !used[f]) begin
                used[f] = 1'b1;
                s_valid[idx] = 1'b0; s_last[idx] = 1'b0; s_data[idx] = 8'h00;
            end else begin
                s_valid[idx] = 1'b1;
                s_data[idx]  = plan_data[ptr];
                s_last[idx]  = (ptr == plan_off[f] + plan_len[f] - 1);
            end
            @(negedge tx_clk);
            sample(idx);
            if (s_ready[idx]) ready_cnt[f] = ready_cnt[f] + 1;
            if (s_valid[idx] && s_ready[idx]) ptr++;
            cyc++;
        end
        accepted = ptr;
        repeat (120) begin
            @(posedge tx_clk); #1;
            s_valid[idx] = 1'b0; s_last[idx] = 1'b0; s_data[idx] = 8'h00;
            @(negedge tx_clk);
            sample(idx);
            if (s_ready[idx]) ready_cnt[plan_len.size()] = ready_cnt[plan_len.size()] + 1;
        end
    endtask

    // Rebuild the expected wire from the framing rules and compare span by span
    task automatic check_run(input int idx, input string name);
        int ss [$];
        int sl [$];
        logic [7:0] exp_b [$];
        logic [7:0] body  [$];
        logic [31:0] crc;
        int nfr, nholes, er_tot, mism, bad_at, er_in, gap_exp, last;
        nfr = plan_len.size();
        nholes = 0; er_tot = 0;
        for (int c = 0; c < en_q.size(); c++) begin
            if (en_q[c] && ((c == 0) || !en_q[c-1])) begin ss.push_back(c); sl.push_back(0); end
            if (en_q[c]) sl[sl.size()-1] = sl[sl.size()-1] + 1;
            if (er_q[c]) er_tot++;
        end
        check({name, " span_count"}, ss.size(), nfr);
        check({name, " accepted"}, accepted, plan_data.size());
        first_start = (ss.size() > 0) ? ss[0] : -1;
        first_len   = (sl.size() > 0) ? sl[0] : -1;
        check({name, " tx_en_rise_cycle"}, first_start, 1);
        for (int f = 0; (f < nfr) && (f < ss.size()); f++) begin
            exp_b.delete(); body.delete();
            for (int k = 0; k < cfg_pre(idx); k++) exp_b.push_back(8'h55);
            exp_b.push_back(8'hD5);
            if (plan_hole[f] >= 0) begin
                nholes++;
                exp_uc[idx]++;
                for (int k = 0; k < plan_hole[f]; k++) exp_b.push_back(plan_data[plan_off[f] + k]);
                exp_b.push_back(8'h00);
            end else begin
                exp_fc[idx]++;
                for (int k = 0; k < plan_len[f]; k++) body.push_back(plan_data[plan_off[f] + k]);
                while (body.size() < cfg_min(idx)) body.push_back(8'h00);
                crc = 32'hFFFFFFFF;
                foreach (body[k]) begin
                    crc = crc ^ {24'h0, body[k]};
                    for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
                end
                crc = ~crc;
                foreach (body[k]) exp_b.push_back(body[k]);
                if (cfg_fcs(idx) != 0)
                    for (int k = 0; k < 4; k++) exp_b.push_back(8'(crc >> (8 * k)));
            end
            check($sformatf("%s f%0d length", name, f), sl[f], exp_b.size());
            mism = 0; bad_at = -1;
            for (int k = 0; k < exp_b.size(); k++)
                if (d_q[ss[f] + k] !== exp_b[k]) begin mism++; if (bad_at < 0) bad_at = k; end
            check($sformatf("%s f%0d byte_mismatches(first@%0d)", name, f, bad_at), mism, 0);
            er_in = 0;
            for (int k = 0; k < sl[f]; k++) if (er_q[ss[f] + k]) er_in++;
            check($sformatf("%s f%0d tx_er_cycles", name, f), er_in, (plan_hole[f] >= 0) ? 1 : 0);
            if (plan_hole[f] >= 0) begin
                last = ss[f] + sl[f] - 1;
                check($sformatf("%s f%0d tx_er_on_last", name, f), {31'd0, er_q[last]}, 1);
            end
            check($sformatf("%s f%0d ready_cycles", name, f), ready_cnt[f],
                  plan_len[f] + ((plan_hole[f] >= 0) ? 1 : 0));
            if ((f > 0) && (f - 1 < ss.size())) begin
                gap_exp = cfg_ifg(idx);
                if (plan_hole[f-1] >= 0) gap_exp = gap_exp + plan_len[f-1] - plan_hole[f-1];
                check($sformatf("%s f%0d idle_gap", name, f), ss[f] - (ss[f-1] + sl[f-1]), gap_exp);
            end
        end
        check({name, " tx_er_total"}, er_tot, nholes);
        check({name, " ready_after_last"}, ready_cnt[nfr], 0);
        check({name, " frame_count"}, frame_count[idx], 16'(exp_fc[idx]));
        check({name, " underrun_count"}, underrun_count[idx], 16'(exp_uc[idx]));
        check({name, " busy_idle"}, {31'd0, busy[idx]}, 0);
    endtask

    initial begin
        int hi, cyc, ptr;
        logic [31:0] check_fcs;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; s_data[i] = 8'h00; s_valid[i] = 1'b0; s_last[i] = 1'b0;
            exp_fc[i] = 0; exp_uc[i] = 0;
        end

        // Reset state
        repeat (3) @(posedge tx_clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset tx_en%0d", i), {31'd0, tx_en[i]}, 0);
            check($sformatf("reset busy%0d", i), {31'd0, busy[i]}, 0);
        end
        check("reset txd", txd[0], 0);
        check("reset tx_er", {31'd0, tx_er[0]}, 0);
        check("reset s_ready", {31'd0, s_ready[0]}, 0);
        check("reset frame_count", frame_count[0], 0);
        check("reset underrun_count", underrun_count[0], 0);
        @(negedge tx_clk);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        // "123456789" with no padding: known CRC32 0xCBF43926
        clear_plan();
        add_frame(9, -1);
        for (int k = 0; k < 9; k++) plan_data[k] = 8'h31 + 8'(k);
        run_frames(1);
        check_run(1, "check9");
        check_fcs = 32'hCBF43926;
        check("check9 sfd", d_q[first_start + 7], 8'hD5);
        for (int k = 0; k < 4; k++)
            check($sformatf("check9 fcs%0d", k), d_q[first_start + 17 + k], 8'(check_fcs >> (8 * k)));

        // Single 0xAB byte padded to 60
        clear_plan();
        add_frame(1, -1);
        plan_data[0] = 8'hAB;
        run_frames(0);
        check_run(0, "pad1");
        check("pad1 tx_en_cycles", first_len, 72);

        // Underrun after 5 bytes, 10 more bytes then s_last
        clear_plan();
        add_frame(15, 5);
        run_frames(0);
        check_run(0, "underrun");

        // Two 64-byte frames back to back
        clear_plan();
        add_frame(64, -1);
        add_frame(64, -1);
        run_frames(0);
        check_run(0, "b2b64");

        // Random lengths around the padding boundary
        clear_plan();
        for (int k = 0; k < 3; k++) add_frame($urandom_range(1, 90), -1);
        run_frames(0);
        check_run(0, "rand_a");

        clear_plan();
        add_frame($urandom_range(1, 40), -1);
        add_frame($urandom_range(2, 30), $urandom_range(1, 1));
        add_frame($urandom_range(1, 40), -1);
        run_frames(1);
        check_run(1, "rand_b");

        // Short preamble, no FCS, single idle cycle
        clear_plan();
        add_frame(5, -1);
        add_frame(70, -1);
        add_frame(20, 8);
        add_frame(60, -1);
        run_frames(2);
        check_run(2, "sweep");
        check("sweep pre2", d_q[first_start + 2], 8'h55);
        check("sweep sfd", d_q[first_start + 3], 8'hD5);

        // Reset while FCS byte 2 is on the wire
        hi = 0; cyc = 0; ptr = 0;
        while ((hi < 7 + 1 + 60 + 2) && (cyc < 500)) begin
            @(posedge tx_clk); #1;
            s_valid[0] = (ptr < 60);
            s_data[0]  = 8'($urandom_range(0, 255));
            s_last[0]  = (ptr == 59);
            @(negedge tx_clk);
            if (tx_en[0]) hi++;
            if (s_valid[0] && s_ready[0]) ptr++;
            cyc++;
        end
        check("midrst reached_fcs", hi, 70);
        #2 rst[0] = 1'b1;
        #1;
        check("midrst tx_en", {31'd0, tx_en[0]}, 0);
        check("midrst busy", {31'd0, busy[0]}, 0);
        check("midrst frame_count", frame_count[0], 0);
        check("midrst underrun_count", underrun_count[0], 0);
        check("midrst txd", txd[0], 0);
        s_valid[0] = 1'b0; s_last[0] = 1'b0;
        @(posedge tx_clk);
        @(negedge tx_clk);
        rst[0] = 1'b0;
        exp_fc[0] = 0; exp_uc[0] = 0;
        clear_plan();
        add_frame($urandom_range(40, 80), -1);
        run_frames(0);
        check_run(0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
